// File: rtl/gb_bus_pkg.sv
// Shared definitions for the memory-bus / OAM DMA slice.
package gb_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_XFER  = 2'd2
    } dma_state_e;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam int unsigned DMA_LEN      = 160;
    localparam logic [7:0]  DMA_LAST     = 8'(DMA_LEN - 1);

    localparam logic [15:0] HRAM_LO      = 16'hFF80;
    localparam logic [15:0] HRAM_HI      = 16'hFFFE;

    localparam logic [1:0]  T0           = 2'd0;
    localparam logic [1:0]  T1           = 2'd1;
    localparam logic [1:0]  T2           = 2'd2;
    localparam logic [1:0]  T3           = 2'd3;

    localparam logic [7:0]  OPEN_BUS     = 8'hFF;

    // Pages at and above 0xE0 are the echo-RAM mirror of 0xC0..; fold them down.
    function automatic logic [7:0] eff_src_hi(input logic [7:0] hi);
        logic [7:0] res;
        if (hi < 8'hE0) begin
            res = hi;
        end else begin
            res = hi - 8'h20;
        end
        return res;
    endfunction

endpackage

// File: rtl/cpu_addr_decode.sv
// Combinational CPU address decoder: HRAM window and DMA source register hit.
module cpu_addr_decode
    import gb_bus_pkg::*;
(
    input  logic [15:0] cpu_addr,
    output logic        hram_sel,
    output logic        is_dma_reg
);

    // Pure address compare; no state.
    always_comb begin
        hram_sel   = (cpu_addr >= HRAM_LO) && (cpu_addr <= HRAM_HI);
        is_dma_reg = (cpu_addr == DMA_REG_ADDR);
    end

endmodule

// File: rtl/oam_dma_ctrl.sv
// OAM DMA engine and CPU/DMA memory-bus arbiter.
// The FSM state, byte index, source page and data latch are registered; the
// bus mux is combinational from that state so CPU accesses see the bus in the
// same cycle and reset takes effect on the outputs immediately.
module oam_dma_ctrl
    import gb_bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  t_cycle,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] mem_addr,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    output logic [7:0]  mem_wdata,
    output logic        mem_ctrl_sel,
    output logic        hram_sel,
    output logic        dma_active,
    output logic        cpu_blocked
);

    dma_state_e  state_r;
    logic [7:0]  idx_r;
    logic [7:0]  src_hi_r;
    logic [7:0]  latch_r;

    logic        hram_sel_s;
    logic        is_dma_reg_s;
    logic        trigger_s;
    logic        cpu_req_s;
    logic [7:0]  eff_hi_s;
    logic [7:0]  bus_rdata_s;

    cpu_addr_decode u_cpu_addr_decode (
        .cpu_addr   (cpu_addr),
        .hram_sel   (hram_sel_s),
        .is_dma_reg (is_dma_reg_s)
    );

    assign hram_sel = hram_sel_s;

    // Trigger qualification and derived request/address terms.
    always_comb begin
        trigger_s = cpu_wr && is_dma_reg_s && (t_cycle == T3);
        cpu_req_s = (cpu_rd || cpu_wr) && !hram_sel_s;
        eff_hi_s  = eff_src_hi(src_hi_r);
    end

    // DMA sequencer: a write to the source register (re)starts from any state,
    // otherwise START waits one M-cycle and XFER moves one byte per M-cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            idx_r    <= 8'h00;
            src_hi_r <= 8'h00;
            latch_r  <= 8'h00;
        end else if (trigger_s) begin
            state_r  <= ST_START;
            idx_r    <= 8'h00;
            src_hi_r <= cpu_wdata;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_START: begin
                    if (t_cycle == T3) begin
                        state_r <= ST_XFER;
                        idx_r   <= 8'h00;
                    end else begin
                        state_r <= ST_START;
                    end
                end
                ST_XFER: begin
                    if (t_cycle == T1) begin
                        latch_r <= mem_rdata;
                    end else begin
                        latch_r <= latch_r;
                    end
                    if (t_cycle == T3) begin
                        if (idx_r == DMA_LAST) begin
                            state_r <= ST_IDLE;
                            idx_r   <= 8'h00;
                        end else begin
                            idx_r   <= idx_r + 8'd1;
                        end
                    end else begin
                        idx_r <= idx_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    idx_r   <= 8'h00;
                end
            endcase
        end
    end

    // Bus mux: CPU passes through in IDLE; in START/XFER the CPU is fenced
    // off the main bus and XFER drives read (t0/t1) then write (t2/t3).
    always_comb begin
        mem_addr     = cpu_addr;
        mem_rd_en    = 1'b0;
        mem_wr_en    = 1'b0;
        mem_wdata    = cpu_wdata;
        mem_ctrl_sel = 1'b0;
        dma_active   = 1'b0;
        cpu_blocked  = 1'b0;
        bus_rdata_s  = mem_rdata;
        case (state_r)
            ST_IDLE: begin
                // Write wins so the two strobes can never overlap.
                mem_rd_en = cpu_rd && !cpu_wr;
                mem_wr_en = cpu_wr;
            end
            ST_START: begin
                dma_active  = 1'b1;
                cpu_blocked = cpu_req_s;
                if (hram_sel_s) begin
                    bus_rdata_s = mem_rdata;
                end else begin
                    bus_rdata_s = OPEN_BUS;
                end
            end
            ST_XFER: begin
                dma_active   = 1'b1;
                mem_ctrl_sel = 1'b1;
                cpu_blocked  = cpu_req_s;
                mem_wdata    = latch_r;
                if (hram_sel_s) begin
                    bus_rdata_s = mem_rdata;
                end else begin
                    bus_rdata_s = OPEN_BUS;
                end
                if ((t_cycle == T0) || (t_cycle == T1)) begin
                    mem_addr  = {eff_hi_s, idx_r};
                    mem_rd_en = 1'b1;
                end else begin
                    mem_addr  = OAM_BASE + {8'h00, idx_r};
                    mem_wr_en = 1'b1;
                end
            end
            default: begin
                mem_addr = cpu_addr;
            end
        endcase
    end

    // Read-data return: the source register reads back in every state.
    always_comb begin
        if (cpu_rd && is_dma_reg_s) begin
            cpu_rdata = src_hi_r;
        end else begin
            cpu_rdata = bus_rdata_s;
        end
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: directed scenarios with randomized
// data and CPU traffic, checked against a transfer-timeline reference model.
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  t_cycle;
    logic [15:0] cpu_addr;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic [7:0]  mem_rdata;
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [7:0]  mem_wdata;
    logic        mem_ctrl_sel;
    logic        hram_sel;
    logic        dma_active;
    logic        cpu_blocked;

    logic [7:0]  mem [0:65535];

    int n_checks = 0;
    int n_errors = 0;
    int act_cnt  = 0;

    // Reference model: whether a transfer is running, clocks since its
    // trigger edge, and the last value written to the source register.
    bit          m_active = 1'b0;
    int          m_since  = 0;
    logic [7:0]  m_src    = 8'h00;

    oam_dma_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .t_cycle      (t_cycle),
        .cpu_addr     (cpu_addr),
        .cpu_rd       (cpu_rd),
        .cpu_wr       (cpu_wr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .mem_rdata    (mem_rdata),
        .mem_addr     (mem_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_wr_en    (mem_wr_en),
        .mem_wdata    (mem_wdata),
        .mem_ctrl_sel (mem_ctrl_sel),
        .hram_sel     (hram_sel),
        .dma_active   (dma_active),
        .cpu_blocked  (cpu_blocked)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs (at posedge+1), check at posedge+4, then advance.
    task automatic step(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d);
        logic        e_hram;
        logic [7:0]  e_hi;
        logic [15:0] src_a;
        int          k;
        int          ph;
        logic        w_en;
        logic [15:0] w_a;
        logic [7:0]  w_d;
        logic [1:0]  tc;
        cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
        #3;
        e_hram = (a >= 16'hFF80) && (a <= 16'hFFFE);
        chk("hram_sel", {15'd0, hram_sel}, {15'd0, e_hram});
        chk("dma_active", {15'd0, dma_active}, {15'd0, m_active});
        if (m_active) begin
            chk("cpu_blocked", {15'd0, cpu_blocked}, {15'd0, (rd || wr) && !e_hram});
            if (rd && a == 16'hFF46) begin
                chk("reg_readback_dma", {8'd0, cpu_rdata}, {8'd0, m_src});
            end else if (rd && !e_hram) begin
                chk("blocked_rdata", {8'd0, cpu_rdata}, 16'h00FF);
            end
            if (m_since < 4) begin
                chk("start_sel", {15'd0, mem_ctrl_sel}, 16'd0);
                chk("start_rd_en", {15'd0, mem_rd_en}, 16'd0);
                chk("start_wr_en", {15'd0, mem_wr_en}, 16'd0);
            end else begin
                k     = (m_since - 4) / 4;
                ph    = (m_since - 4) % 4;
                e_hi  = (m_src < 8'hE0) ? m_src : (m_src - 8'h20);
                src_a = {e_hi, k[7:0]};
                chk("xfer_sel", {15'd0, mem_ctrl_sel}, 16'd1);
                if (ph < 2) begin
                    chk("xfer_rd_en", {15'd0, mem_rd_en}, 16'd1);
                    chk("xfer_wr_en", {15'd0, mem_wr_en}, 16'd0);
                    chk("xfer_rd_addr", mem_addr, src_a);
                end else begin
                    chk("xfer_rd_en", {15'd0, mem_rd_en}, 16'd0);
                    chk("xfer_wr_en", {15'd0, mem_wr_en}, 16'd1);
                    chk("xfer_wr_addr", mem_addr, 16'hFE00 + 16'(k));
                    chk("xfer_wdata", {8'd0, mem_wdata}, {8'd0, mem[src_a]});
                end
            end
        end else begin
            chk("idle_blocked", {15'd0, cpu_blocked}, 16'd0);
            chk("idle_sel", {15'd0, mem_ctrl_sel}, 16'd0);
            chk("idle_addr", mem_addr, a);
            chk("idle_rd_en", {15'd0, mem_rd_en}, {15'd0, rd});
            chk("idle_wr_en", {15'd0, mem_wr_en}, {15'd0, wr});
            if (rd) begin
                chk("idle_rdata", {8'd0, cpu_rdata}, {8'd0, (a == 16'hFF46) ? m_src : mem[a]});
            end
        end
        w_en = mem_wr_en; w_a = mem_addr; w_d = mem_wdata; tc = t_cycle;
        if (dma_active === 1'b1) act_cnt++;
        @(posedge clk);
        #1;
        if (w_en === 1'b1 && !$isunknown(w_a)) mem[w_a] = w_d;
        if (rst_n && wr && a == 16'hFF46 && tc == 2'd3) begin
            m_active = 1'b1; m_since = 0; m_src = d;
        end else if (m_active) begin
            m_since++;
            if (m_since == 644) m_active = 1'b0;
        end
        t_cycle = t_cycle + 2'd1;
    endtask

    task automatic trigger(input logic [7:0] src);
        int guard = 0;
        while (t_cycle != 2'd3 && guard < 8) begin
            step(1'b0, 1'b0, 16'h0000, 8'h00);
            guard++;
        end
        step(1'b0, 1'b1, 16'hFF46, src);
    endtask

    // Random CPU traffic while a transfer runs; idle otherwise.
    task automatic run(input int n, input bit noise);
        logic [15:0] a;
        int          op;
        for (int i = 0; i < n; i++) begin
            if (noise && m_active) begin
                op = $urandom_range(0, 3);
                a  = 16'($urandom);
                if (a == 16'hFF46) a = 16'h1234;
                case (op)
                    1: step(1'b1, 1'b0, a, 8'h00);
                    2: step(1'b0, 1'b1, a, 8'($urandom));
                    3: step(1'($urandom), 1'b0, 16'($urandom_range(16'hFF80, 16'hFFFE)), 8'($urandom));
                    default: step(1'b0, 1'b0, a, 8'h00);
                endcase
            end else begin
                step(1'b0, 1'b0, 16'h0000, 8'h00);
            end
        end
    endtask

    task automatic check_oam(input logic [7:0] src);
        logic [7:0] e_hi;
        int         bad = 0;
        e_hi = (src < 8'hE0) ? src : (src - 8'h20);
        for (int i = 0; i < 160; i++) begin
            if (mem[16'hFE00 + 16'(i)] !== mem[{e_hi, 8'(i)}]) bad++;
        end
        chk("oam_copy_bad_bytes", 16'(bad), 16'd0);
    endtask

    task automatic reset_pulse();
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h1234; cpu_wdata = 8'h00;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_dma_active", {15'd0, dma_active}, 16'd0);
        chk("rst_sel", {15'd0, mem_ctrl_sel}, 16'd0);
        chk("rst_blocked", {15'd0, cpu_blocked}, 16'd0);
        chk("rst_rd_en", {15'd0, mem_rd_en}, 16'd0);
        chk("rst_wr_en", {15'd0, mem_wr_en}, 16'd0);
        chk("rst_addr", mem_addr, 16'h1234);
        m_active = 1'b0; m_since = 0; m_src = 8'h00;
        @(posedge clk);
        #1;
        t_cycle = t_cycle + 2'd1;
    endtask

    initial begin
        logic [7:0] s;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        rst_n = 1'b0; t_cycle = 2'd0;
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
        @(posedge clk);
        #1;
        // Reset state, including source register readback of 00.
        step(1'b0, 1'b0, 16'h4321, 8'h00);
        step(1'b1, 1'b0, 16'hFF46, 8'h00);
        rst_n = 1'b1;
        run(6, 1'b0);

        // Plain copy from page C0, exact occupancy.
        act_cnt = 0;
        trigger(8'hC0);
        run(650, 1'b0);
        chk("occupancy_c0", 16'(act_cnt), 16'd644);
        check_oam(8'hC0);

        // Echo page E1 folds to C1, with blocked CPU traffic interleaved.
        act_cnt = 0;
        trigger(8'hE1);
        run(30, 1'b0);
        step(1'b1, 1'b0, 16'h1234, 8'h00);
        step(1'b0, 1'b1, 16'hFF90, 8'h5A);
        step(1'b1, 1'b0, 16'hFF46, 8'h00);
        run(620, 1'b1);
        chk("occupancy_e1", 16'(act_cnt), 16'd644);
        check_oam(8'hE1);

        // Retrigger with D0 fifty M-cycles after the first trigger.
        s = 8'($urandom);
        act_cnt = 0;
        trigger(s);
        run(199, 1'b1);
        step(1'b0, 1'b1, 16'hFF46, 8'hD0);
        run(660, 1'b0);
        chk("occupancy_retrigger", 16'(act_cnt), 16'd844);
        check_oam(8'hD0);

        // Reset in the middle of byte 80.
        trigger(8'($urandom));
        run(4 + 80 * 4 + 2, 1'b1);
        reset_pulse();
        run(3, 1'b0);
        rst_n = 1'b1;
        act_cnt = 0;
        run(40, 1'b0);
        chk("post_reset_quiet", 16'(act_cnt), 16'd0);
        step(1'b1, 1'b0, 16'hFF46, 8'h00);

        // Readback after a DMA of 8A; a mis-phased register write is ignored.
        trigger(8'h8A);
        run(650, 1'b1);
        step(1'b1, 1'b0, 16'hFF46, 8'h00);
        while (t_cycle != 2'd1) step(1'b0, 1'b0, 16'h0000, 8'h00);
        act_cnt = 0;
        step(1'b0, 1'b1, 16'hFF46, 8'h33);
        run(20, 1'b0);
        chk("no_dma_at_t1", 16'(act_cnt), 16'd0);
        step(1'b1, 1'b0, 16'hFF46, 8'h00);

        // A couple of fully random transfers.
        for (int r = 0; r < 2; r++) begin
            s = 8'($urandom);
            act_cnt = 0;
            trigger(s);
            run(650, 1'b1);
            chk("occupancy_rand", 16'(act_cnt), 16'd644);
            check_oam(s);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
